// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM state encodings and
// the default Hack word width.
package serial_subtractor_pkg;

  localparam int unsigned HACK_WORD = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/fullsubtractor.sv
// Combinational 1-bit full subtractor: diff = a - b - bin, with borrow out.
module fullsubtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (a - b, LSB first) with start/done handshake.
// Optional zero flag output `zr` enabled by defining SERIAL_SUB_ZERO_FLAG_EN.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int unsigned WIDTH = HACK_WORD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
`ifdef SERIAL_SUB_ZERO_FLAG_EN
  output logic             zr,
`endif
  output logic             borrow
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

  state_e           r_state;
  state_e           w_state_next;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow;
  logic [CW-1:0]    r_cnt;
  logic             w_d;
  logic             w_bout;
  logic [WIDTH-1:0] w_diff_shift;
  logic             w_last;

  fullsubtractor u_cell (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_borrow),
    .diff (w_d),
    .bout (w_bout)
  );

  assign w_diff_shift = {w_d, r_diff[WIDTH-1:1]};
  assign w_last       = (r_cnt == LAST_CNT);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_next = S_RUN;
      S_RUN:   if (w_last) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand shifters, result shifter, borrow flop and bit counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= 1'b0;
            r_cnt    <= '0;
          end
        end
        S_RUN: begin
          r_a      <= r_a >> 1;
          r_b      <= r_b >> 1;
          r_diff   <= w_diff_shift;
          r_borrow <= w_bout;
          r_cnt    <= r_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef SERIAL_SUB_ZERO_FLAG_EN
  logic r_zr;

  // Only refreshed on the final bit so it holds through the next RUN
  always_ff @(posedge clk) begin
    if (rst) begin
      r_zr <= 1'b1;
    end else if (r_state == S_RUN && w_last) begin
      r_zr <= (w_diff_shift == '0);
    end
  end

  assign zr = r_zr;
`endif

  assign diff   = r_diff;
  assign borrow = r_borrow;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor at WIDTH = 16.
// zr checks are active only when SERIAL_SUB_ZERO_FLAG_EN is defined.
module tb_serial_subtractor;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
  logic         zr_obs;

  int errors;
  int checks;

  serial_subtractor #(
    .WIDTH (W)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    .zr     (zr_obs),
`endif
    .borrow (borrow)
  );

`ifndef SERIAL_SUB_ZERO_FLAG_EN
  assign zr_obs = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Launch one operation and wait for it; returns observed values in DONE.
  task automatic do_op(input logic [W-1:0] ia, input logic [W-1:0] ib,
                       output int nbusy, output logic done_at, output logic [W-1:0] d,
                       output logic br, output logic z, output logic done_after,
                       output logic busy_after);
    a = ia;
    b = ib;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    nbusy = 0;
    while (busy === 1'b1 && nbusy < 100) begin
      nbusy++;
      @(posedge clk);
      #1;
    end
    done_at = done;
    d = diff;
    br = borrow;
    z = zr_obs;
    @(posedge clk);
    #1;
    done_after = done;
    busy_after = busy;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    a = '0;
    b = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (diff !== 16'h0000) begin errors++; $display("FAIL reset_diff got=%h exp=0000", diff); end
    checks++; if (borrow !== 1'b0) begin errors++; $display("FAIL reset_borrow got=%b exp=0", borrow); end
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    checks++; if (zr_obs !== 1'b1) begin errors++; $display("FAIL reset_zr got=%b exp=1", zr_obs); end
`endif
  endtask

  task automatic test_basic();
    int nb; logic da, br, z, dn, bs; logic [W-1:0] d;
    do_op(16'd5, 16'd3, nb, da, d, br, z, dn, bs);
    checks++; if (nb != 16) begin errors++; $display("FAIL basic_busy_cycles got=%0d exp=16", nb); end
    checks++; if (da !== 1'b1) begin errors++; $display("FAIL basic_done got=%b exp=1", da); end
    checks++; if (d !== 16'h0002) begin errors++; $display("FAIL basic_diff got=%h exp=0002", d); end
    checks++; if (br !== 1'b0) begin errors++; $display("FAIL basic_borrow got=%b exp=0", br); end
    checks++; if (diff !== 16'h0002) begin errors++; $display("FAIL basic_hold got=%h exp=0002", diff); end
  endtask

  task automatic test_negative();
    int nb; logic da, br, z, dn, bs; logic [W-1:0] d;
    do_op(16'd3, 16'd5, nb, da, d, br, z, dn, bs);
    checks++; if (da !== 1'b1) begin errors++; $display("FAIL neg_done got=%b exp=1", da); end
    checks++; if (d !== 16'hFFFE) begin errors++; $display("FAIL neg_diff got=%h exp=fffe", d); end
    checks++; if (br !== 1'b1) begin errors++; $display("FAIL neg_borrow got=%b exp=1", br); end
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    checks++; if (z !== 1'b0) begin errors++; $display("FAIL neg_zr got=%b exp=0", z); end
`endif
  endtask

  task automatic test_zero();
    int nb; logic da, br, z, dn, bs; logic [W-1:0] d;
    do_op(16'h1234, 16'h1234, nb, da, d, br, z, dn, bs);
    checks++; if (da !== 1'b1) begin errors++; $display("FAIL zero_done got=%b exp=1", da); end
    checks++; if (d !== 16'h0000) begin errors++; $display("FAIL zero_diff got=%h exp=0000", d); end
    checks++; if (br !== 1'b0) begin errors++; $display("FAIL zero_borrow got=%b exp=0", br); end
    checks++; if (dn !== 1'b0) begin errors++; $display("FAIL zero_done_one_cycle got=%b exp=0", dn); end
    checks++; if (bs !== 1'b0) begin errors++; $display("FAIL zero_idle_busy got=%b exp=0", bs); end
`ifdef SERIAL_SUB_ZERO_FLAG_EN
    checks++; if (z !== 1'b1) begin errors++; $display("FAIL zero_zr got=%b exp=1", z); end
`endif
  endtask

  task automatic test_msb_boundary();
    int nb; logic da, br, z, dn, bs; logic [W-1:0] d;
    do_op(16'h8000, 16'h0001, nb, da, d, br, z, dn, bs);
    checks++; if (d !== 16'h7FFF) begin errors++; $display("FAIL msb1_diff got=%h exp=7fff", d); end
    checks++; if (br !== 1'b0) begin errors++; $display("FAIL msb1_borrow got=%b exp=0", br); end
    do_op(16'h0000, 16'hFFFF, nb, da, d, br, z, dn, bs);
    checks++; if (d !== 16'h0001) begin errors++; $display("FAIL msb2_diff got=%h exp=0001", d); end
    checks++; if (br !== 1'b1) begin errors++; $display("FAIL msb2_borrow got=%b exp=1", br); end
  endtask

  task automatic test_ignored_start();
    int n;
    int extra_done;
    a = 16'd5;
    b = 16'd3;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    // Pulse across one RUN edge with different operands
    a = 16'hFFFF;
    b = 16'h0000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (done !== 1'b1 && n < 100) begin
      n++;
      @(posedge clk);
      #1;
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL ign_done got=%b exp=1", done); end
    checks++; if (diff !== 16'h0002) begin errors++; $display("FAIL ign_diff got=%h exp=0002", diff); end
    a = 16'h00F0;
    b = 16'h000F;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_done_start_busy got=%b exp=0", busy); end
    extra_done = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (done === 1'b1 || busy === 1'b1) extra_done++;
    end
    checks++; if (extra_done != 0) begin errors++; $display("FAIL ign_no_extra got=%0d exp=0", extra_done); end
    checks++; if (diff !== 16'h0002) begin errors++; $display("FAIL ign_hold got=%h exp=0002", diff); end
  endtask

  task automatic test_reset_mid();
    int nb; logic da, br, z, dn, bs; logic [W-1:0] d;
    a = 16'hFFFF;
    b = 16'h0001;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rmid_done got=%b exp=0", done); end
    checks++; if (diff !== 16'h0000) begin errors++; $display("FAIL rmid_diff got=%h exp=0000", diff); end
    checks++; if (borrow !== 1'b0) begin errors++; $display("FAIL rmid_borrow got=%b exp=0", borrow); end
    do_op(16'd10, 16'd4, nb, da, d, br, z, dn, bs);
    checks++; if (nb != 16) begin errors++; $display("FAIL rmid_busy_cycles got=%0d exp=16", nb); end
    checks++; if (d !== 16'h0006) begin errors++; $display("FAIL rmid_fresh_diff got=%h exp=0006", d); end
    checks++; if (br !== 1'b0) begin errors++; $display("FAIL rmid_fresh_borrow got=%b exp=0", br); end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_basic();
    test_negative();
    test_zero();
    test_msb_boundary();
    test_ignored_start();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
